// File: rtl/axis_uart_tx.sv
// AXI-stream byte to asynchronous UART frame serializer (8 data bits, optional parity, one stop bit).
// Outputs are all registered; one frame is sent per accepted ivalid/iready handshake.
module axis_uart_tx #(
    parameter int DIVIDER = 104,
    parameter int PARITY  = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic       txd,
    output logic       busy
);

    localparam int CW = (DIVIDER < 2) ? 1 : $clog2(DIVIDER);
    localparam logic [CW-1:0] BAUD_MAX = CW'(DIVIDER - 1);

    if (DIVIDER < 2) begin : g_bad_divider
        $error("axis_uart_tx: DIVIDER must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("axis_uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] baud;
    logic [2:0]    bitidx;
    logic [7:0]    shreg;
    logic          parbit;
    logic          accept;
    logic          boundary;

    function automatic logic parity_of(input logic [7:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    assign accept   = (state == ST_IDLE) && ivalid && iready;
    assign boundary = (baud == '0);

    // Control path: state, baud/bit counters and the registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            baud   <= '0;
            bitidx <= '0;
            txd    <= 1'b1;
            busy   <= 1'b0;
            iready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    iready <= 1'b1;
                    busy   <= 1'b0;
                    txd    <= 1'b1;
                    if (accept) begin
                        state  <= ST_START;
                        baud   <= BAUD_MAX;
                        iready <= 1'b0;
                        busy   <= 1'b1;
                        txd    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (boundary) begin
                        state  <= ST_DATA;
                        baud   <= BAUD_MAX;
                        bitidx <= '0;
                        txd    <= shreg[0];
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (boundary) begin
                        baud <= BAUD_MAX;
                        if (bitidx == 3'd7) begin
                            if (PARITY != 0) begin
                                state <= ST_PARITY;
                                txd   <= parbit;
                            end else begin
                                state <= ST_STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            // shreg shifts on this same edge, so the next bit is still at [1]
                            bitidx <= bitidx + 3'd1;
                            txd    <= shreg[1];
                        end
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (boundary) begin
                        state <= ST_STOP;
                        baud  <= BAUD_MAX;
                        txd   <= 1'b1;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (boundary) begin
                        state  <= ST_IDLE;
                        iready <= 1'b1;
                        busy   <= 1'b0;
                        txd    <= 1'b1;
                    end else begin
                        baud <= baud - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    baud   <= '0;
                    bitidx <= '0;
                    txd    <= 1'b1;
                    busy   <= 1'b0;
                    iready <= 1'b0;
                end
            endcase
        end
    end

    // Data path: byte capture and LSB-first shifting, no reset needed.
    always_ff @(posedge clock) begin
        if (accept) begin
            shreg  <= idata;
            parbit <= parity_of(idata);
        end else if (state == ST_DATA && boundary) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

endmodule
